// File: rtl/flash_erase_ctrl.sv
// SPI-flash (M25P16-class) erase sequencer, SPI mode 0, MSB first.
// Runs WREN, sector or bulk erase, then polls RDSR until WIP clears or POLL_MAX bytes elapse.
module flash_erase_ctrl #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned POLL_MAX = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cs_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);
    localparam int unsigned SW = 8 + ADDR_W;
    localparam int unsigned BW = $clog2(SW + 1);
    localparam int unsigned DW = $clog2(CLK_DIV + 1);
    localparam int unsigned GW = $clog2(CS_GAP + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [15:0]   POLL_LIM = 16'(POLL_MAX);

    typedef enum logic [2:0] {S_IDLE, S_WREN, S_GAP1, S_ERASE, S_GAP2, S_POLL, S_FIN} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SW-1:0]     sh_q, sh_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic [DW-1:0]     div_q, div_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [15:0]       pcnt_q, pcnt_d, pcnt_nx;
    logic              rx_q, rx_d, tail_q, tail_d, wip_q, wip_d, wip_nx, tmo_q, tmo_d;
    logic              cs_n_q, cs_n_d, sck_q, sck_d, busy_q, busy_d;
    logic              done_q, done_d, error_q, error_d;
    logic              load, in_frame;
    logic [SW-1:0]     ld_data;
    logic [BW-1:0]     ld_len;

    // mosi is the shifter MSB: it drains to zero, so it idles low and reads zero while polling
    assign mosi  = sh_q[SW-1];
    assign cs_n  = cs_n_q;
    assign sck   = sck_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        bits_d  = bits_q;
        div_d   = div_q;
        gap_d   = gap_q;
        pcnt_d  = pcnt_q;
        rx_d    = rx_q;
        tail_d  = tail_q;
        tmo_d   = tmo_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        load    = 1'b0;
        ld_data = '0;
        ld_len  = '0;
        wip_nx  = (sck_q && div_q == '0) ? miso : wip_q;
        wip_d   = wip_nx;
        pcnt_nx = (pcnt_q == '1) ? pcnt_q : pcnt_q + 16'd1;
        in_frame = state_q inside {S_WREN, S_ERASE, S_POLL};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    addr_d  = addr;
                    busy_d  = 1'b1;
                    tmo_d   = 1'b0;
                    pcnt_d  = '0;
                    state_d = S_WREN;
                    load    = 1'b1;
                    ld_data = {8'h06, {ADDR_W{1'b0}}};
                    ld_len  = BW'(8);
                end
            end
            S_GAP1: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_ERASE;
                    load    = 1'b1;
                    if (mode_q) begin
                        ld_data = {8'hC7, {ADDR_W{1'b0}}};
                        ld_len  = BW'(8);
                    end else begin
                        ld_data = {8'hD8, addr_q};
                        ld_len  = BW'(SW);
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_GAP2: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_POLL;
                    load    = 1'b1;
                    ld_data = {8'h05, {ADDR_W{1'b0}}};
                    ld_len  = BW'(8);
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: ;
        endcase

        if (in_frame) begin
            if (tail_q) begin
                tail_d = 1'b0;
                cs_n_d = 1'b1;
                gap_d  = '0;
                case (state_q)
                    S_WREN:  state_d = S_GAP1;
                    S_ERASE: state_d = S_GAP2;
                    default: begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        error_d = tmo_q;
                    end
                endcase
            end else if (div_q != DIV_LAST) begin
                div_d = div_q + DW'(1);
            end else begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    // falling SCK: bit finished, next bit (or zero) goes out
                    sck_d = 1'b0;
                    sh_d  = {sh_q[SW-2:0], 1'b0};
                    if (bits_q != BW'(1)) begin
                        bits_d = bits_q - BW'(1);
                    end else if (state_q != S_POLL) begin
                        tail_d = 1'b1;
                    end else if (!rx_q) begin
                        rx_d   = 1'b1;
                        bits_d = BW'(8);
                    end else begin
                        pcnt_d = pcnt_nx;
                        if (!wip_nx) begin
                            tail_d = 1'b1;
                        end else if (pcnt_nx == POLL_LIM) begin
                            tail_d = 1'b1;
                            tmo_d  = 1'b1;
                        end else begin
                            bits_d = BW'(8);
                        end
                    end
                end
            end
        end

        if (load) begin
            cs_n_d = 1'b0;
            sck_d  = 1'b0;
            div_d  = '0;
            sh_d   = ld_data;
            bits_d = ld_len;
            tail_d = 1'b0;
            rx_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            sh_q    <= '0;
            bits_q  <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            pcnt_q  <= '0;
            rx_q    <= 1'b0;
            tail_q  <= 1'b0;
            wip_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            bits_q  <= bits_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            pcnt_q  <= pcnt_d;
            rx_q    <= rx_d;
            tail_q  <= tail_d;
            wip_q   <= wip_d;
            tmo_q   <= tmo_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end
endmodule

// File: tb/tb_flash_erase_ctrl.sv
// Bench for flash_erase_ctrl: a table of erase sequences decoded off the SPI pins,
// plus hand-written start-while-busy and reset-mid-frame cases.
module tb_flash_erase_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] addr = '0;
    logic        miso = 1'b0;
    logic        busy0, done0, err0, cs0, sck0, mosi0;
    logic        busy1, done1, err1, cs1, sck1, mosi1;
    logic        m_busy, m_done, m_err, m_cs, m_sck, m_mosi;
    bit          sel = 1'b0;
    int          nerr = 0;
    int          nchk = 0;

    always #5 clk = ~clk;

    flash_erase_ctrl #(.CLK_DIV(2), .CS_GAP(4), .ADDR_W(24), .POLL_MAX(4)) u0 (
        .sys_clk(clk), .sys_rst(rst), .start(start0), .mode(mode), .addr(addr),
        .busy(busy0), .done(done0), .error(err0), .cs_n(cs0), .sck(sck0),
        .mosi(mosi0), .miso(miso)
    );

    flash_erase_ctrl #(.CLK_DIV(1), .CS_GAP(1), .ADDR_W(24), .POLL_MAX(4)) u1 (
        .sys_clk(clk), .sys_rst(rst), .start(start1), .mode(mode), .addr(addr),
        .busy(busy1), .done(done1), .error(err1), .cs_n(cs1), .sck(sck1),
        .mosi(mosi1), .miso(miso)
    );

    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_err  = sel ? err1  : err0;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_sck  = sel ? sck1  : sck0;
    assign m_mosi = sel ? mosi1 : mosi0;

    typedef struct {
        bit          sel;    // 0: CLK_DIV=2/CS_GAP=4, 1: CLK_DIV=1/CS_GAP=1
        bit          mode;
        logic [23:0] addr;
        logic [31:0] st;     // status bytes from flash, first in [31:24]; last repeats
        logic [31:0] erase;  // expected erase frame, right-justified
        int          ebits;
        int          nstat;
        bit          err;
        int          per;    // cycles between SCK rises
        int          gap;
        int          wcs;    // WREN cs_n-low cycles
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_seq(input vec_t v, input bit inj);
        int cyc, nfr, fbits, cslow, gapc, last_rise, pmin, pmax, wcs;
        int ebits, pbits, ones, ndone, j, k, b, viol;
        int gaps[2];
        logic [7:0]  wren, pcmd, sb;
        logic [31:0] eval;
        logic pcs, psck, errv, csd, busyd;
        bit fin;
        nfr = 0; fbits = 0; cslow = 0; gapc = 0; last_rise = -1; pmin = 1000; pmax = 0;
        wcs = 0; ebits = 0; pbits = 0; ones = 0; ndone = 0; viol = 0;
        gaps[0] = -1; gaps[1] = -1;
        wren = '0; pcmd = '0; eval = '0; errv = 1'b0; csd = 1'b0; busyd = 1'b0;
        sel = v.sel;
        @(negedge clk);
        mode = v.mode;
        addr = v.addr;
        if (v.sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        chk("busy_after_start", int'(m_busy), 1);
        chk("cs_after_start", int'(m_cs), 0);
        pcs = 1'b1; psck = 1'b0; cyc = 1; fin = 1'b0;
        while (!fin && cyc < 2000) begin
            if (inj && cyc == 10) begin
                mode = ~v.mode;
                addr = ~v.addr;
            end
            if (inj && cyc == 60) begin
                if (v.sel) start1 = 1'b1; else start0 = 1'b1;
            end
            if (inj && cyc == 61) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if (!m_cs) begin
                if (pcs) begin
                    nfr++;
                    if (nfr >= 2 && nfr <= 3) gaps[nfr-2] = gapc;
                    fbits = 0; cslow = 0; last_rise = -1;
                end
                cslow++;
                if (m_sck && !psck) begin
                    if (last_rise >= 0) begin
                        if (cyc - last_rise < pmin) pmin = cyc - last_rise;
                        if (cyc - last_rise > pmax) pmax = cyc - last_rise;
                    end
                    last_rise = cyc;
                    case (nfr)
                        1: wren = {wren[6:0], m_mosi};
                        2: begin eval = {eval[30:0], m_mosi}; ebits++; end
                        3: if (fbits < 8) pcmd = {pcmd[6:0], m_mosi};
                           else if (m_mosi) ones++;
                        default: ;
                    endcase
                    fbits++;
                    if (nfr == 3) pbits = fbits;
                end
                // flash side: present the next status bit while SCK is low
                if (!m_sck && nfr == 3 && fbits >= 8) begin
                    j = fbits - 8; k = j / 8; b = 7 - (j % 8);
                    sb = (k < 4) ? v.st[31 - 8*k -: 8] : v.st[7:0];
                    miso = sb[b];
                end
            end else begin
                if (!pcs) begin
                    if (nfr == 1) wcs = cslow;
                    gapc = 0;
                end
                gapc++;
                miso = 1'b0;
            end
            pcs = m_cs;
            psck = m_sck;
            if (m_done) begin
                ndone++;
                errv = m_err;
                csd = m_cs;
                busyd = m_busy;
                if (inj) begin
                    if (v.sel) start1 = 1'b1; else start0 = 1'b1;
                end
                @(negedge clk);
                start0 = 1'b0;
                start1 = 1'b0;
                chk("busy_after_done", int'(m_busy), 0);
                chk("done_width", int'(m_done), 0);
                fin = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("seq_finished", int'(fin), 1);
        chk("frames", nfr, 3);
        chk("wren_byte", int'(wren), 'h06);
        chk("wren_cs_cycles", wcs, v.wcs);
        chk("gap1", gaps[0], v.gap);
        chk("gap2", gaps[1], v.gap);
        chk("erase_bits", ebits, v.ebits);
        chk("erase_data", int'(eval), int'(v.erase));
        chk("rdsr_byte", int'(pcmd), 'h05);
        chk("status_bits", pbits, 8 + 8 * v.nstat);
        chk("mosi_ones_in_status", ones, 0);
        chk("bit_period_min", pmin, v.per);
        chk("bit_period_max", pmax, v.per);
        chk("done_pulses", ndone, 1);
        chk("error", int'(errv), int'(v.err));
        chk("cs_high_at_done", int'(csd), 1);
        chk("busy_at_done", int'(busyd), 1);
        if (inj) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m_busy || !m_cs) viol++;
            end
            chk("no_queued_sequence", viol, 0);
        end
    endtask

    initial begin
        //           sel mode addr         status         erase          ebits nstat err per gap wcs
        tbl[0] = '{1'b0, 1'b0, 24'h123456, 32'h03030000, 32'hD8123456, 32, 3, 1'b0, 4, 4, 33};
        tbl[1] = '{1'b0, 1'b1, 24'hFFFFFF, 32'h01000000, 32'h000000C7,  8, 2, 1'b0, 4, 4, 33};
        tbl[2] = '{1'b0, 1'b0, 24'hABCDEF, 32'hFFFFFFFF, 32'hD8ABCDEF, 32, 4, 1'b1, 4, 4, 33};
        tbl[3] = '{1'b0, 1'b0, 24'h5A00A5, 32'h80000000, 32'hD85A00A5, 32, 1, 1'b0, 4, 4, 33};
        tbl[4] = '{1'b1, 1'b0, 24'h123456, 32'h03030000, 32'hD8123456, 32, 3, 1'b0, 2, 1, 17};
        tbl[5] = '{1'b1, 1'b1, 24'h000000, 32'h00000000, 32'h000000C7,  8, 1, 1'b0, 2, 1, 17};
        tbl[6] = '{1'b1, 1'b1, 24'h800001, 32'h81818181, 32'h000000C7,  8, 4, 1'b1, 2, 1, 17};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", int'(cs0 & cs1), 1);
        chk("rst_sck", int'(sck0 | sck1), 0);
        chk("rst_mosi", int'(mosi0 | mosi1), 0);
        chk("rst_busy", int'(busy0 | busy1), 0);
        chk("rst_done_error", int'(done0 | done1 | err0 | err1), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_seq(tbl[i], 1'b0);

        // start pulsed mid-ERASE and in FIN, mode/addr wiggled while busy
        run_seq(tbl[0], 1'b1);
        run_seq(tbl[1], 1'b0);

        // synchronous reset in the middle of the first address byte
        sel = 1'b0;
        @(negedge clk);
        mode = 1'b0;
        addr = 24'h123456;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (79) @(negedge clk);
        chk("cs_low_before_reset", int'(cs0), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cs_n", int'(cs0), 1);
        chk("midrst_sck", int'(sck0), 0);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_mosi", int'(mosi0), 0);
        chk("midrst_done", int'(done0), 0);
        run_seq(tbl[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
